// File: rtl/gpio_pkg.sv
// Register map and width default for the gpio_controller bank, shared with firmware header generation.
package gpio_pkg;

  localparam int GPIO_WIDTH = 16;

  // Register index = byte offset >> 2
  typedef enum logic [2:0] {
    GPIO_DIR      = 3'd0,
    GPIO_OUT      = 3'd1,
    GPIO_IN       = 3'd2,
    GPIO_SET      = 3'd3,
    GPIO_CLR      = 3'd4,
    GPIO_TGL      = 3'd5,
    GPIO_IRQ_MASK = 3'd6,
    GPIO_IRQ_STAT = 3'd7
  } gpio_reg_e;

  function automatic logic [4:0] gpio_offset(input gpio_reg_e r);
    return {r, 2'b00};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pin input synchroniser: 2 flops plus a prev stage for rising-edge detect; latency 2 edges to sync.
// No handshake; samples every cycle.
module gpio_sync #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= pins;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/gpio_controller.sv
// GPIO bus slave: DIR/OUT/IN/SET/CLR/TGL, optional edge IRQ under GPIO_IRQ_EN; read latency 1 cycle.
// Backpressure: one access per req while ack=0, ack pulses one cycle, so held req completes every 2 cycles.
module gpio_controller
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [4:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             ack,
  inout  wire  [WIDTH-1:0] gpioPorts,
  output logic             irq
);

  gpio_reg_e        sel;
  logic             acc;
  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] mask_val;
  logic [WIDTH-1:0] stat_val;
  logic [31:0]      rd_val;

  assign acc = req & ~ack;
  assign wr  = acc & we;
  assign sel = gpio_reg_e'(addr[4:2]);
  assign wd  = wdata[WIDTH-1:0];

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk  (clk),
    .reset(reset),
    .pins (gpioPorts),
    .sync (in_sync),
    .rise (rise)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign gpioPorts[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_q <= '0;
      out_q <= '0;
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= acc;
      rdata <= (acc && !we) ? rd_val : '0;
      if (wr) begin
        case (sel)
          GPIO_DIR: dir_q <= wd;
          GPIO_OUT: out_q <= wd;
          GPIO_SET: out_q <= out_q | wd;
          GPIO_CLR: out_q <= out_q & ~wd;
          GPIO_TGL: out_q <= out_q ^ wd;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      GPIO_DIR:      rd_val[WIDTH-1:0] = dir_q;
      GPIO_OUT:      rd_val[WIDTH-1:0] = out_q;
      GPIO_IN:       rd_val[WIDTH-1:0] = in_sync;
      GPIO_IRQ_MASK: rd_val[WIDTH-1:0] = mask_val;
      GPIO_IRQ_STAT: rd_val[WIDTH-1:0] = stat_val;
      default:       rd_val = '0;
    endcase
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] clr;

  assign clr = (wr && sel == GPIO_IRQ_STAT) ? wd : '0;

  // New edges are OR'd in after the clear so a coincident edge keeps its bit set
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q <= '0;
      stat_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr && sel == GPIO_IRQ_MASK) mask_q <= wd;
      stat_q <= (stat_q & ~clr) | (rise & mask_q);
      irq    <= |stat_q;
    end
  end

  assign mask_val = mask_q;
  assign stat_val = stat_q;
`else
  logic unused_rise;
  assign unused_rise = ^rise;
  assign mask_val    = '0;
  assign stat_val    = '0;
  assign irq         = 1'b0;
`endif

  logic unused_bus;
  assign unused_bus = ^{addr[1:0], wdata[31:WIDTH]};

endmodule

// File: tb/tb_gpio_controller.sv
// Randomised self-checking bench for gpio_controller against a register/pin-history reference model.
module tb_gpio_controller;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  wire  [31:0] rdata;
  wire         ack;
  wire         irq;
  wire [W-1:0] gpioPorts;

  logic [W-1:0] tb_drv = '0;
  logic [W-1:0] drv_dir = '0;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  // Reference model state
  logic [W-1:0] m_dir = '0;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_mask = '0;
  logic [W-1:0] m_stat = '0;
  logic [W-1:0] hist [0:2] = '{default: '0};
  logic         e_ack = 1'b0;
  logic         e_irq = 1'b0;
  logic [31:0]  e_rdata = '0;

  gpio_controller dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .gpioPorts(gpioPorts),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  for (genvar i = 0; i < W; i++) begin : g_drv
    assign gpioPorts[i] = drv_dir[i] ? 1'bz : tb_drv[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      3'd0: v[W-1:0] = m_dir;
      3'd1: v[W-1:0] = m_out;
      3'd2: v[W-1:0] = hist[1];
`ifdef GPIO_IRQ_EN
      3'd6: v[W-1:0] = m_mask;
      3'd7: v[W-1:0] = m_stat;
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  // Model: pins seen at edge k become readable as IN at edge k+2
  always @(posedge clk) begin
    logic [W-1:0] pin_now;
    logic [W-1:0] wd;
    logic         acc;
    logic [31:0]  rd;
    pin_now = (m_dir & m_out) | (~m_dir & tb_drv);
    wd      = wdata[W-1:0];
    if (!reset) begin
      m_dir = '0; m_out = '0; m_mask = '0; m_stat = '0;
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
      e_ack = 1'b0; e_irq = 1'b0; e_rdata = '0;
    end else begin
      acc = req && !e_ack;
      rd  = (acc && !we) ? model_read(addr[4:2]) : 32'd0;
`ifdef GPIO_IRQ_EN
      begin : irq_model
        logic [W-1:0] rise;
        logic [W-1:0] nstat;
        rise  = hist[1] & ~hist[2];
        e_irq = (m_stat != '0);
        nstat = m_stat | (rise & m_mask);
        if (acc && we && addr[4:2] == 3'd7) nstat = (m_stat & ~wd) | (rise & m_mask);
        if (acc && we && addr[4:2] == 3'd6) m_mask = wd;
        m_stat = nstat;
      end
`endif
      if (acc && we) begin
        case (addr[4:2])
          3'd0: m_dir = wd;
          3'd1: m_out = wd;
          3'd3: m_out = m_out | wd;
          3'd4: m_out = m_out & ~wd;
          3'd5: m_out = m_out ^ wd;
          default: ;
        endcase
      end
      e_ack   = acc;
      e_rdata = rd;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = pin_now;
    end
    drv_dir <= m_dir;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", {31'b0, ack}, {31'b0, e_ack});
      chk("rdata", rdata, e_rdata);
      chk("irq", {31'b0, irq}, {31'b0, e_irq});
      chk("pins", {16'b0, gpioPorts}, {16'b0, (m_dir & m_out) | (~m_dir & tb_drv)});
    end
  end

  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d, output logic [31:0] r);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    chk("bus_ack", {31'b0, ack}, 32'd1);
    r = rdata;
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset  = 1'b1;

    // Reset values
    bus(1'b0, 5'h00, 32'd0, r); chk("rst_dir", r, 32'h0);
    bus(1'b0, 5'h04, 32'd0, r); chk("rst_out", r, 32'h0);

    // Low byte driven, high byte from bench; IN needs two extra edges
    tb_drv = 16'hA500;
    bus(1'b1, 5'h00, 32'h0000_00FF, r);
    bus(1'b1, 5'h04, 32'h0000_1234, r);
    chk("pins_lo", {24'b0, gpioPorts[7:0]}, 32'h34);
    cycles(1);
    bus(1'b0, 5'h08, 32'd0, r); chk("in_read", r, 32'h0000_A534);

    // SET/CLR/TGL
    bus(1'b1, 5'h04, 32'h0000_00F0, r);
    bus(1'b1, 5'h0C, 32'h0000_000F, r);
    bus(1'b1, 5'h10, 32'h0000_0030, r);
    bus(1'b1, 5'h14, 32'h0000_0101, r);
    bus(1'b0, 5'h04, 32'd0, r); chk("out_rmw", r, 32'h0000_01CE);
    bus(1'b1, 5'h08, 32'hFFFF_FFFF, r);
    bus(1'b0, 5'h0C, 32'd0, r); chk("wo_read0", r, 32'h0);

    // Input pin 9 rise: not yet visible at 1st edge, visible from 3rd
    tb_drv[9] = 1'b1;
    bus(1'b0, 5'h08, 32'd0, r); chk("in9_early", {31'b0, r[9]}, 32'd0);
    bus(1'b0, 5'h08, 32'd0, r); chk("in9_late", {31'b0, r[9]}, 32'd1);

`ifdef GPIO_IRQ_EN
    tb_drv[9] = 1'b0;
    cycles(4);
    bus(1'b1, 5'h18, 32'h0000_0200, r);
    tb_drv[9] = 1'b1;
    cycles(6);
    chk("irq_set", {31'b0, irq}, 32'd1);
    bus(1'b0, 5'h1C, 32'd0, r); chk("stat_set", r, 32'h0000_0200);
    bus(1'b1, 5'h1C, 32'h0000_0200, r);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    tb_drv[9] = 1'b0;
    cycles(4);
    tb_drv[9] = 1'b1;
    cycles(2);
    bus(1'b1, 5'h1C, 32'h0000_0200, r);
    bus(1'b0, 5'h1C, 32'd0, r); chk("stat_edge_wins", r, 32'h0000_0200);
    chk("irq_again", {31'b0, irq}, 32'd1);
`else
    bus(1'b1, 5'h18, 32'h0000_FFFF, r);
    bus(1'b0, 5'h18, 32'd0, r); chk("mask_absent", r, 32'h0);
    chk("irq_tied", {31'b0, irq}, 32'd0);
`endif

    // Held req: one access every 2 cycles, then reset during ack
    req = 1'b1; we = 1'b0; addr = 5'h04;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("hold_ack", {31'b0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    chk("hold_ack_last", {31'b0, ack}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    req = 1'b0;
    reset = 1'b1;
    bus(1'b0, 5'h00, 32'd0, r); chk("rst2_dir", r, 32'h0);
    bus(1'b0, 5'h04, 32'd0, r); chk("rst2_out", r, 32'h0);

    // Random traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      req   = ($urandom % 3) != 0;
      we    = $urandom % 2;
      addr  = 5'($urandom % 32);
      wdata = $urandom;
      if ($urandom % 8 == 0) tb_drv = W'($urandom);
      reset = ($urandom % 200) != 0;
      @(posedge clk); #1;
    end
    req = 1'b0;
    reset = 1'b1;
    cycles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
